sram_like_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Sits between the pipeline and the AXI bridge / cache.
- Arbitrates address phases, holds the grant until the address handshake completes, and routes in-order responses back through a requester-ID FIFO.

---
 rtl/sram_like_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one SRAM-like port between the IF and MEM requesters.
//               The address phase is arbitrated with a combinational grant
//               that is held across stalled cycles. In-order responses are
//               routed back through a requester-ID FIFO.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration instead of the default fixed priority, where
//               data wins over inst.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int OUT_PTR_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    // IF requester
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // MEM requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared slave port
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam logic [1:0] c_st_idle       = 2'd0;
    localparam logic [1:0] c_st_grant_inst = 2'd1;
    localparam logic [1:0] c_st_grant_data = 2'd2;

    localparam logic [OUT_PTR_W:0] c_depth = (OUT_PTR_W + 1)'(OUTSTANDING);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    // requester-ID FIFO: one bit per slot, 0 = inst, 1 = data
    logic [OUTSTANDING-1:0] r_id;
    logic [OUT_PTR_W-1:0]   r_wr_ptr;
    logic [OUT_PTR_W-1:0]   r_rd_ptr;
    logic [OUT_PTR_W:0]     r_count;

    logic                   w_full;
    logic                   w_pick_data;
    logic                   w_sel_valid;
    logic                   w_sel_data;
    logic                   w_sel_req;
    logic                   w_sram_req;
    logic                   w_hs;
    logic                   w_pop;
    logic                   w_head;

    assign w_full = (r_count == c_depth);

`ifdef ARB_ROUND_ROBIN_EN
    // points at the requester that wins when both ask (0 = inst, 1 = data)
    logic r_rr_data;

    // after each accepted address, favour the requester that was not served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_data <= 1'b0;
        end else if (w_hs) begin
            r_rr_data <= ~w_sel_data;
        end
    end

    assign w_pick_data = data_req && (!inst_req || r_rr_data);
`else
    assign w_pick_data = data_req;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // owner of the port this cycle: the held grant, or the fresh winner in idle
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = 1'b0;
        case (r_state)
            c_st_grant_inst: begin
                w_sel_valid = 1'b1;
                w_sel_data  = 1'b0;
            end
            c_st_grant_data: begin
                w_sel_valid = 1'b1;
                w_sel_data  = 1'b1;
            end
            default: begin
                w_sel_valid = inst_req || data_req;
                w_sel_data  = w_pick_data;
            end
        endcase
    end

    assign w_sel_req  = w_sel_data ? data_req : inst_req;
    // reset is folded in so the port goes quiet the moment reset rises
    assign w_sram_req = w_sel_valid && w_sel_req && !w_full && !reset;
    assign w_hs       = w_sram_req && sram_addr_ok;

    // next state: hold the grant only across a stalled address phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_sram_req && !sram_addr_ok) begin
                    w_state_nxt = w_sel_data ? c_st_grant_data : c_st_grant_inst;
                end
            end
            c_st_grant_inst: begin
                if (!inst_req || w_hs) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_grant_data: begin
                if (!data_req || w_hs) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_pop  = sram_data_ok && (r_count != '0);
    assign w_head = r_id[r_rd_ptr];

    // outputs: route the owner onto the port and the response to the FIFO head
    always_comb begin
        sram_req     = w_sram_req;
        sram_wr      = w_sel_data ? data_wr    : inst_wr;
        sram_size    = w_sel_data ? data_size  : inst_size;
        sram_wstrb   = w_sel_data ? data_wstrb : inst_wstrb;
        sram_addr    = w_sel_data ? data_addr  : inst_addr;
        sram_wdata   = w_sel_data ? data_wdata : inst_wdata;
        inst_addr_ok = w_hs && !w_sel_data;
        data_addr_ok = w_hs &&  w_sel_data;
        inst_data_ok = w_pop && !w_head;
        data_data_ok = w_pop &&  w_head;
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

    // ID FIFO: push on every address handshake, pop on every matched response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_hs) begin
                r_id[r_wr_ptr] <= w_sel_data;
                r_wr_ptr       <= r_wr_ptr + OUT_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + OUT_PTR_W'(1);
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + (OUT_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (OUT_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Randomized self-checking bench for sram_like_arbiter. A
//               queue-based reference model predicts every port value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    localparam int OUTSTANDING = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(OUTSTANDING), .OUT_PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // requester transaction state (index 0 = inst, 1 = data)
    bit          pend  [2];
    bit          t_wr  [2];
    logic [1:0]  t_size[2];
    logic [3:0]  t_strb[2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wd  [2];

    // reference model: accepted-but-unanswered requester IDs in order,
    // requester currently holding the port (-1 = none), preferred requester
    int q[$];
    int lock = -1;
    int rr   = 0;
    int max_depth = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_inputs();
        inst_req   = pend[0];   data_req   = pend[1];
        inst_wr    = t_wr[0];   data_wr    = t_wr[1];
        inst_size  = t_size[0]; data_size  = t_size[1];
        inst_wstrb = t_strb[0]; data_wstrb = t_strb[1];
        inst_addr  = t_addr[0]; data_addr  = t_addr[1];
        inst_wdata = t_wd[0];   data_wdata = t_wd[1];
    endtask

    task automatic clear_model();
        q.delete();
        lock = -1;
        rr   = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    endtask

    // one clock of random stimulus; percentages: new request, addr_ok, data_ok
    task automatic run_cycle(input int p_new, input int p_aok, input int p_dok);
        int  g;
        bit  full, ereq, hs, pop;
        int  head;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ($urandom_range(99) < p_new)) begin
                pend[r]   = 1'b1;
                t_wr[r]   = 1'($urandom_range(1));
                t_size[r] = 2'($urandom_range(3));
                t_strb[r] = 4'($urandom);
                t_addr[r] = $urandom;
                t_wd[r]   = $urandom;
            end else if (pend[r] && ($urandom_range(99) < 3)) begin
                pend[r] = 1'b0;
            end
        end
        drive_inputs();
        sram_addr_ok = ($urandom_range(99) < p_aok);
        sram_data_ok = ($urandom_range(99) < p_dok);
        sram_rdata   = $urandom;
        @(negedge clk);

        full = (q.size() >= OUTSTANDING);
        if (lock >= 0)                g = lock;
`ifdef ARB_ROUND_ROBIN_EN
        else if (pend[0] && pend[1])  g = rr;
`else
        else if (pend[0] && pend[1])  g = 1;
`endif
        else if (pend[1])             g = 1;
        else if (pend[0])             g = 0;
        else                          g = -1;
        ereq = (g >= 0) && pend[g] && !full;
        hs   = ereq && sram_addr_ok;
        pop  = sram_data_ok && (q.size() > 0);
        head = (q.size() > 0) ? q[0] : -1;

        check("sram_req", 32'(sram_req), 32'(ereq));
        if (ereq) begin
            check("sram_addr",  sram_addr,  t_addr[g]);
            check("sram_wdata", sram_wdata, t_wd[g]);
            check("sram_ctl",   32'({sram_wr, sram_size, sram_wstrb}),
                                32'({t_wr[g], t_size[g], t_strb[g]}));
        end
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(hs && g == 0));
        check("data_addr_ok", 32'(data_addr_ok), 32'(hs && g == 1));
        check("inst_data_ok", 32'(inst_data_ok), 32'(pop && head == 0));
        check("data_data_ok", 32'(data_data_ok), 32'(pop && head == 1));
        check("inst_rdata", inst_rdata, sram_rdata);
        check("data_rdata", data_rdata, sram_rdata);

        if (lock >= 0) begin
            if (!pend[lock] || hs) lock = -1;
        end else if (ereq && !hs) begin
            lock = g;
        end
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(g);
            pend[g] = 1'b0;
            rr = 1 - g;
        end
        if (q.size() > max_depth) max_depth = q.size();
    endtask

    initial begin
        clear_model();
        for (int r = 0; r < 2; r++) begin
            t_wr[r] = 1'b0; t_size[r] = 2'd0; t_strb[r] = 4'd0;
            t_addr[r] = 32'd0; t_wd[r] = 32'd0;
        end
        drive_inputs();
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
        sram_rdata   = 32'd0;
        reset        = 1'b1;
        // a request present during reset must not reach the port
        inst_req     = 1'b1;
        data_req     = 1'b1;
        sram_addr_ok = 1'b1;
        sram_data_ok = 1'b1;
        #12;
        check("rst_sram_req",     32'(sram_req),     32'd0);
        check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
        @(posedge clk);
        #1;
        drive_inputs();
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
        reset = 1'b0;

        repeat (400) run_cycle(60, 60, 30);
        // slow responses so the ID FIFO fills and back-pressures
        repeat (400) run_cycle(80, 80, 10);
        repeat (400) run_cycle(40, 50, 70);
        check("fifo_reached_full", 32'(max_depth), 32'(OUTSTANDING));

        // build outstanding work, then reset in the middle of a stall
        repeat (8) run_cycle(90, 60, 0);
        @(posedge clk);
        #1;
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        drive_inputs();
        sram_addr_ok = 1'b1;
        sram_data_ok = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_sram_req",     32'(sram_req),     32'd0);
        check("mid_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("mid_rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("mid_rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("mid_rst_data_data_ok", 32'(data_data_ok), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        drive_inputs();
        sram_addr_ok = 1'b0;
        reset = 1'b0;
        // stray response right after reset release must be dropped
        @(negedge clk);
        check("stray_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("stray_data_data_ok", 32'(data_data_ok), 32'd0);

        repeat (300) run_cycle(50, 60, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
